// File: rtl/mem_if_pkg.sv
// mem_if_pkg: shared state encoding, RW codes and data width for the data-memory responder
package mem_if_pkg;
  localparam int DATA_W = 32;
  localparam logic RW_READ = 1'b1;
  localparam logic RW_WRITE = 1'b0;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;
endpackage

// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if: CPU data-memory bus between the memory controller (master) and the responder (slave)
//   mem_req/RW/address_in/RAM_in : request from master, held stable until mem_ready
//   RAM_out/mem_ready/addr_err/busy : response and status from slave
interface data_mem_responder_if;
  import mem_if_pkg::*;
  logic              mem_req;
  logic              RW;
  logic [DATA_W-1:0] address_in;
  logic [DATA_W-1:0] RAM_in;
  logic [DATA_W-1:0] RAM_out;
  logic              mem_ready;
  logic              addr_err;
  logic              busy;
  modport master (output mem_req, RW, address_in, RAM_in, input RAM_out, mem_ready, addr_err, busy);
  modport slave (input mem_req, RW, address_in, RAM_in, output RAM_out, mem_ready, addr_err, busy);
endinterface

// File: rtl/data_mem_responder_ram_array.sv
// ram_array: DEPTH x 32 single-port word storage with write enable and registered read
//   i_we/i_addr/i_wdata : write port; i_re loads o_rdata, i_rclr forces the loaded value to zero
//   o_rdata             : registered read data, holds between reads, cleared by reset
module ram_array
  import mem_if_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              Reset_n,
  input  logic              i_we,
  input  logic              i_re,
  input  logic              i_rclr,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_q;
  // array contents survive reset; only the read register is cleared
  always_ff @(posedge clk)
    if (i_we) r_mem[i_addr] <= i_wdata;
  always_ff @(posedge clk or negedge Reset_n)
    if (!Reset_n) r_q <= '0;
    else if (i_re) r_q <= i_rclr ? '0 : r_mem[i_addr];
  assign o_rdata = r_q;
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: serialized word-access responder with programmable wait states and range check
//   clk, Reset_n : clock and asynchronous active-low reset
//   bus          : slave side of the data-memory bus (request in, RAM_out/mem_ready/addr_err/busy out)
module data_mem_responder
  import mem_if_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int ADDR_W      = 8,
  parameter int WAIT_STATES = 2
) (
  input logic                 clk,
  input logic                 Reset_n,
  data_mem_responder_if.slave bus
);
  state_t            r_state, w_next;
  logic [3:0]        r_cnt, w_cnt;
  logic              r_rw;
  logic [DATA_W-1:0] r_addr, r_data, w_rdata;
  logic              w_oor, w_we, w_re;
  assign w_oor = |r_addr[DATA_W-1:ADDR_W];
  always_ff @(posedge clk or negedge Reset_n)
    if (!Reset_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_rw    <= RW_READ;
      r_addr  <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt;
      if (r_state == ST_IDLE && bus.mem_req) begin
        r_rw   <= bus.RW;
        r_addr <= bus.address_in;
        r_data <= bus.RAM_in;
      end
    end
  always_comb begin
    w_next = r_state;
    w_cnt  = r_cnt;
    w_we   = 1'b0;
    w_re   = 1'b0;
    case (r_state)
      ST_IDLE: if (bus.mem_req) begin
        w_cnt  = 4'(WAIT_STATES);
        w_next = WAIT_STATES == 0 ? ST_ACCESS : ST_WAIT;
      end
      ST_WAIT: begin
        w_cnt  = r_cnt - 4'd1;
        w_next = r_cnt == 4'd1 ? ST_ACCESS : ST_WAIT;
      end
      ST_ACCESS: begin
        // out-of-range reads still load the read register, but with zero
        w_we   = r_rw == RW_WRITE && !w_oor;
        w_re   = r_rw == RW_READ;
        w_next = ST_RESP;
      end
      default: w_next = ST_IDLE;
    endcase
  end
  ram_array #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
    .clk     (clk),
    .Reset_n (Reset_n),
    .i_we    (w_we),
    .i_re    (w_re),
    .i_rclr  (w_oor),
    .i_addr  (r_addr[ADDR_W-1:0]),
    .i_wdata (r_data),
    .o_rdata (w_rdata)
  );
  assign bus.RAM_out   = w_rdata;
  assign bus.mem_ready = r_state == ST_RESP;
  assign bus.addr_err  = r_state == ST_RESP && w_oor;
  assign bus.busy      = r_state != ST_IDLE;
endmodule
